multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Define MULTICYCLE_CTRL_HALT_EN to park in HALT on an illegal opcode; otherwise an illegal opcode retires as a NOP.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  aluop,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        adrsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  resultsrc,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_MEMADR = 4'd4;
    localparam logic [3:0] S_MEMRD  = 4'd5;
    localparam logic [3:0] S_MEMWB  = 4'd6;
    localparam logic [3:0] S_MEMWR  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd11;

    logic [3:0]  state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        is_store_q, is_store_d;
    logic        retire;

    logic op_rtype, op_imm, op_load, op_store, op_branch, op_jump;

    assign op_rtype  = (op[4] == 1'b0);
    assign op_imm    = (op[4:3] == 2'b10);
    assign op_load   = (op == 5'b11000);
    assign op_store  = (op == 5'b11001);
    assign op_branch = (op == 5'b11010);
    assign op_jump   = (op == 5'b11011);

    // op is only valid in DECODE, so the load/store choice is latched there for MEMADR.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                is_store_d = op_store;
                if (op_rtype)                   state_d = S_EXEC_R;
                else if (op_imm)                state_d = S_EXEC_I;
                else if (op_load || op_store)   state_d = S_MEMADR;
                else if (op_branch)             state_d = S_BRANCH;
                else if (op_jump)               state_d = S_JUMP;
                else begin
`ifdef MULTICYCLE_CTRL_HALT_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
                    retire  = 1'b1;
`endif
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign instr_count_d = instr_count_q + {15'd0, retire};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= 16'd0;
            is_store_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            is_store_q    <= is_store_d;
        end
    end

    logic pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;

    always_comb begin
        aluop        = 2'b00;
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memread      = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        adrsrc       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                memread     = 1'b1;
                alusrcb     = 2'b01;
                resultsrc   = 2'b10;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
            end
            S_EXEC_R: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_EXEC_I: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                resultsrc    = 2'b01;
            end
            S_MEMWR: begin
                memwrite_raw = 1'b1;
                adrsrc       = 1'b1;
            end
            S_ALUWB: regwrite_raw = 1'b1;
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwrite_raw = zero;
            end
            S_JUMP: begin
                pcwrite_raw = 1'b1;
                resultsrc   = 2'b10;
                alusrcb     = 2'b10;
            end
            default: ;
        endcase
    end

    // Write enables are suppressed while reset is asserted so an interrupted access cannot commit.
    assign pcwrite     = pcwrite_raw  & rst_n;
    assign irwrite     = irwrite_raw  & rst_n;
    assign memwrite    = memwrite_raw & rst_n;
    assign regwrite    = regwrite_raw & rst_n;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule
